// File: rtl/gate_check_pkg.sv
// gate_check_pkg: FSM state type and truth tables for the 2-input gates the checker can verify.
package gate_check_pkg;
   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
   localparam logic [3:0] TT_NOR2  = 4'b0001;
   localparam logic [3:0] TT_NAND2 = 4'b0111;
   localparam logic [3:0] TT_AND2  = 4'b1000;
   localparam logic [3:0] TT_OR2   = 4'b1110;
   localparam logic [3:0] TT_XOR2  = 4'b0110;
endpackage

// File: rtl/gate_response_checker_if.sv
// gate_response_checker_if: checker control/status and the DUT stimulus/response signals.
// GRC_FAIL_CAPTURE_EN adds the fail_mask/first_fail capture outputs.
interface gate_response_checker_if #(parameter int N_IN = 2);
   localparam int NV = 2**N_IN;
   localparam int EW = $clog2(NV + 1);
   logic            start;
   logic            dut_f;
   logic [N_IN-1:0] stim;
   logic            busy;
   logic            done;
   logic            pass;
   logic [EW-1:0]   err_count;
`ifdef GRC_FAIL_CAPTURE_EN
   logic [NV-1:0]   fail_mask;
   logic [N_IN-1:0] first_fail;
   logic            first_fail_vld;
   modport master (input start, dut_f, output stim, busy, done, pass, err_count, fail_mask, first_fail, first_fail_vld);
   modport slave (output start, dut_f, input stim, busy, done, pass, err_count, fail_mask, first_fail, first_fail_vld);
`else
   modport master (input start, dut_f, output stim, busy, done, pass, err_count);
   modport slave (output start, dut_f, input stim, busy, done, pass, err_count);
`endif
endinterface

// File: rtl/grc_settle_timer.sv
// grc_settle_timer: loadable up-counter flagging the last cycle of the settle window.
module grc_settle_timer #(
   parameter int TERM = 4,
   parameter int W    = TERM > 1 ? $clog2(TERM) : 1
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic tc
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk) cnt <= (rst || load) ? '0 : en ? cnt + 1'b1 : cnt;
   assign tc = cnt == W'(TERM - 1);
endmodule

// File: rtl/gate_response_checker.sv
// gate_response_checker: walks all input vectors of a gate DUT, compares against GATE_TT, reports done/pass.
// Optional GRC_FAIL_CAPTURE_EN records which vectors failed and the first failing one.
module gate_response_checker
   import gate_check_pkg::*;
#(
   parameter int                   N_IN          = 2,
   parameter int                   SETTLE_CYCLES = 4,
   parameter logic [2**N_IN-1:0]   GATE_TT       = TT_NOR2
) (
   input logic clk,
   input logic rst,
   gate_response_checker_if.master bus
);
   localparam int EW = $clog2(2**N_IN + 1);
   state_t          state, nxt;
   logic            tc, kick, samp, last, mis;
   logic [N_IN-1:0] stim;
   logic [EW-1:0]   err;
   grc_settle_timer #(.TERM(SETTLE_CYCLES)) u_timer (
      .clk,
      .rst,
      .load(kick | (samp & ~last)),
      .en  (state == SETTLE),
      .tc
   );
   always_ff @(posedge clk) state <= rst ? IDLE : nxt;
   always_comb
      nxt = (state == IDLE || state == DONE) ? (bus.start ? SETTLE : state)
          : state == SETTLE ? (tc ? SAMPLE : SETTLE)
          : (last ? DONE : SETTLE);
   always_comb begin
      kick          = (state == IDLE || state == DONE) && bus.start;
      samp          = state == SAMPLE;
      last          = &stim;
      mis           = bus.dut_f != GATE_TT[stim];
      bus.busy      = state == SETTLE || state == SAMPLE;
      bus.done      = state == DONE;
      bus.pass      = state == DONE && err == '0;
      bus.stim      = stim;
      bus.err_count = err;
   end
   // err cannot exceed 2**N_IN: one increment per vector, cleared every run
   always_ff @(posedge clk)
      if (rst || kick) begin
         stim <= '0;
         err  <= '0;
      end else if (samp) begin
         err  <= err + EW'(mis);
         stim <= last ? stim : stim + 1'b1;
      end
`ifdef GRC_FAIL_CAPTURE_EN
   logic [2**N_IN-1:0] mask;
   logic [N_IN-1:0]    first;
   logic               first_vld;
   always_ff @(posedge clk)
      if (rst || kick) begin
         mask      <= '0;
         first     <= '0;
         first_vld <= 1'b0;
      end else if (samp && mis) begin
         mask[stim] <= 1'b1;
         first      <= first_vld ? first : stim;
         first_vld  <= 1'b1;
      end
   assign bus.fail_mask      = mask;
   assign bus.first_fail     = first;
   assign bus.first_fail_vld = first_vld;
`endif
endmodule

// File: tb/tb_gate_response_checker.sv
// tb_gate_response_checker: scoreboard bench; stimulus queues expected run results, monitors check on done.
// Fail-capture checks compile in when GRC_FAIL_CAPTURE_EN is defined.
module tb_gate_response_checker;
   import gate_check_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   gate_response_checker_if #(.N_IN(2)) b1 ();
   gate_response_checker_if #(.N_IN(2)) b2 ();
   gate_response_checker #(.N_IN(2)) dut1 (.clk(clk), .rst(rst), .bus(b1.master));
   gate_response_checker #(.N_IN(2), .SETTLE_CYCLES(1), .GATE_TT(TT_NAND2)) dut2 (.clk(clk), .rst(rst), .bus(b2.master));
   int mode = 0;
   assign b1.dut_f = mode == 0 ? ~(b1.stim[1] | b1.stim[0]) : mode == 1 ? 1'b0 : (b1.stim[1] | b1.stim[0]);
   assign b2.dut_f = ~(b2.stim[1] & b2.stim[0]);
   typedef struct {
      string name;
      int    t0;
      int    len;
      int    err;
      int    pass;
      int    mask;
   } exp_t;
   exp_t q1[$], q2[$];
   int cyc = 0, checks = 0, passes = 0;
   always @(posedge clk) cyc++;
   function automatic void chk(input string n, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d", n, act, exp);
   endfunction
   // monitor for the default NOR checker: vector hold/order plus end-of-run scoreboard
   bit pd1 = 0, pb1 = 0;
   int cur1, run1;
   exp_t e1;
   always @(negedge clk) begin
      if (b1.busy && !pb1) begin
         chk("m1_first_stim", int'(b1.stim), 0);
         cur1 = int'(b1.stim);
         run1 = 1;
      end else if (b1.busy) begin
         if (int'(b1.stim) == cur1) run1++;
         else begin
            chk("m1_hold", run1, 5);
            chk("m1_step", int'(b1.stim), cur1 + 1);
            cur1 = int'(b1.stim);
            run1 = 1;
         end
      end
      if (b1.done && !pd1) begin
         chk("m1_last_hold", run1, 5);
         if (q1.size() == 0) begin
            checks++;
            $display("FAIL m1_unexpected_done: got done=1 expected no run pending");
         end else begin
            e1 = q1.pop_front();
            chk({e1.name, "_len"}, cyc - e1.t0, e1.len);
            chk({e1.name, "_err"}, int'(b1.err_count), e1.err);
            chk({e1.name, "_pass"}, int'(b1.pass), e1.pass);
            chk({e1.name, "_stim_hold"}, int'(b1.stim), 3);
`ifdef GRC_FAIL_CAPTURE_EN
            chk({e1.name, "_mask"}, int'(b1.fail_mask), e1.mask);
            chk({e1.name, "_ffvld"}, int'(b1.first_fail_vld), e1.err != 0 ? 1 : 0);
            if (e1.err != 0) chk({e1.name, "_first"}, int'(b1.first_fail), 0);
`endif
         end
      end
      pd1 = b1.done;
      pb1 = b1.busy;
   end
   // monitor for the NAND checker with a one-cycle settle window
   bit pd2 = 0, pb2 = 0;
   int cur2, run2;
   exp_t e2;
   always @(negedge clk) begin
      if (b2.busy && !pb2) begin
         cur2 = int'(b2.stim);
         run2 = 1;
      end else if (b2.busy) begin
         if (int'(b2.stim) == cur2) run2++;
         else begin
            chk("m2_hold", run2, 2);
            chk("m2_step", int'(b2.stim), cur2 + 1);
            cur2 = int'(b2.stim);
            run2 = 1;
         end
      end
      if (b2.done && !pd2) begin
         if (q2.size() == 0) begin
            checks++;
            $display("FAIL m2_unexpected_done: got done=1 expected no run pending");
         end else begin
            e2 = q2.pop_front();
            chk({e2.name, "_len"}, cyc - e2.t0, e2.len);
            chk({e2.name, "_err"}, int'(b2.err_count), e2.err);
            chk({e2.name, "_pass"}, int'(b2.pass), e2.pass);
         end
      end
      pd2 = b2.done;
      pb2 = b2.busy;
   end
   task automatic go1(input string n, input int m, input int err, input int p, input int mask);
      mode = m;
      @(negedge clk);
      b1.start = 1'b1;
      q1.push_back('{n, cyc + 1, 20, err, p, mask});
      @(negedge clk);
      b1.start = 1'b0;
   endtask
   task automatic wait_done1(input string n);
      for (int i = 0; i < 100 && !b1.done; i++) @(negedge clk);
      if (!b1.done) begin
         checks++;
         $display("FAIL %s_timeout: got done=0 expected done=1 within 100 cycles", n);
      end
   endtask
   initial begin
      b1.start = 1'b0;
      b2.start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(b1.busy), 0);
      chk("rst_done", int'(b1.done), 0);
      chk("rst_pass", int'(b1.pass), 0);
      chk("rst_err", int'(b1.err_count), 0);
      chk("rst_stim", int'(b1.stim), 0);
      chk("rst_busy2", int'(b2.busy), 0);
      rst = 1'b0;
      go1("nor", 0, 0, 1, 0);
      wait_done1("nor");
      go1("stuck0", 1, 1, 0, 1);
      wait_done1("stuck0");
      go1("rerun", 0, 0, 1, 0);
      chk("rerun_clr_err", int'(b1.err_count), 0);
      chk("rerun_clr_done", int'(b1.done), 0);
      chk("rerun_busy", int'(b1.busy), 1);
      wait_done1("rerun");
      go1("or", 2, 4, 0, 15);
      wait_done1("or");
      go1("repulse", 0, 0, 1, 0);
      repeat (5) @(negedge clk);
      b1.start = 1'b1;
      @(negedge clk);
      b1.start = 1'b0;
      wait_done1("repulse");
      mode = 1;
      @(negedge clk);
      b1.start = 1'b1;
      @(negedge clk);
      b1.start = 1'b0;
      for (int i = 0; i < 50 && b1.stim != 2'd2; i++) @(negedge clk);
      chk("abort_reach_stim2", int'(b1.stim), 2);
      chk("abort_err_before", int'(b1.err_count), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", int'(b1.busy), 0);
      chk("abort_done", int'(b1.done), 0);
      chk("abort_stim", int'(b1.stim), 0);
      chk("abort_err", int'(b1.err_count), 0);
      go1("after_rst", 0, 0, 1, 0);
      wait_done1("after_rst");
      @(negedge clk);
      b2.start = 1'b1;
      q2.push_back('{"nand2", cyc + 1, 8, 0, 1, 0});
      @(negedge clk);
      b2.start = 1'b0;
      for (int i = 0; i < 50 && !b2.done; i++) @(negedge clk);
      if (!b2.done) begin
         checks++;
         $display("FAIL nand2_timeout: got done=0 expected done=1 within 50 cycles");
      end
      repeat (3) @(negedge clk);
      chk("q1_drained", q1.size(), 0);
      chk("q2_drained", q2.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish before 20000 cycles");
      $fatal(1);
   end
endmodule
